// File: rtl/adc_seqctrl_if.sv
// Conversion request and result hand-off between adc_seqctrl (master) and its consumer (slave).
// Handshake: result moves when result_valid && result_ready on a rising clk; result_valid never drops without that.
interface adc_seqctrl_if #(
    parameter int NBITS = 16
);
    logic             start;
    logic             busy;
    logic [NBITS-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             overrun;

    modport master (
        input  start,
        input  result_ready,
        output busy,
        output result,
        output result_valid,
        output overrun
    );

    modport slave (
        output start,
        output result_ready,
        input  busy,
        input  result,
        input  result_valid,
        input  overrun
    );
endinterface

// File: rtl/adc_seqctrl.sv
// SAR ADC phase sequencer and MSB-first comp_out deserialiser with a valid/ready result port.
// Optional ADC_SEQ_CONT_EN adds the cont input for back-to-back conversions.
module adc_seqctrl #(
    parameter int NBITS       = 16,
    parameter int SAMP_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic                clk,
    input  logic                rst,
    adc_seqctrl_if.master       bus,
    output logic                seq_init,
    output logic                seq_samp,
    output logic                seq_comp,
    output logic                seq_update,
    input  logic                comp_out,
`ifdef ADC_SEQ_CONT_EN
    input  logic                cont,
`endif
    output logic [2:0]          state_dbg
);
    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(NBITS - 1);
    localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(SAMP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        SAMP   = 3'd2,
        COMP   = 3'd3,
        LATCH  = 3'd4,
        UPDATE = 3'd5
    } state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [NBITS-1:0] sr, sr_next;
    logic             done;
    logic             cont_go;

`ifdef ADC_SEQ_CONT_EN
    assign cont_go = cont;
`else
    assign cont_go = 1'b0;
`endif

    assign state_dbg = state;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        sr_next    = sr;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = INIT;
                    idx_next   = IDX_TOP;
                    sr_next    = '0;
                end
            end
            INIT: begin
                state_next = SAMP;
                cnt_next   = '0;
            end
            SAMP: begin
                if (cnt == SAMP_LAST) state_next = COMP;
                else                  cnt_next   = cnt + 1'b1;
            end
            COMP:  state_next = LATCH;
            LATCH: begin
                sr_next[idx] = comp_out;
                state_next   = UPDATE;
            end
            UPDATE: begin
                if (idx != '0) begin
                    idx_next   = idx - 1'b1;
                    state_next = COMP;
                end else begin
                    // Last decision taken; in continuous mode the next conversion restarts at INIT.
                    done       = 1'b1;
                    idx_next   = IDX_TOP;
                    state_next = cont_go ? INIT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            idx              <= '0;
            cnt              <= '0;
            sr               <= '0;
            seq_init         <= 1'b0;
            seq_samp         <= 1'b0;
            seq_comp         <= 1'b0;
            seq_update       <= 1'b0;
            bus.busy         <= 1'b0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.overrun      <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            cnt        <= cnt_next;
            sr         <= sr_next;
            // Strobes and busy are registered decodes of the state being entered.
            seq_init   <= (state_next == INIT);
            seq_samp   <= (state_next == SAMP);
            seq_comp   <= (state_next == COMP);
            seq_update <= (state_next == UPDATE);
            bus.busy   <= (state_next != IDLE);
            if (done) begin
                bus.result       <= sr;
                bus.result_valid <= 1'b1;
                if (bus.result_valid && !bus.result_ready) bus.overrun <= 1'b1;
            end else if (bus.result_valid && bus.result_ready) begin
                bus.result_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adc_seqctrl.sv
// Bench for adc_seqctrl: default instance against a cycle-offset model, plus an NBITS=1 instance.
module tb_adc_seqctrl;
    localparam int N    = 16;
    localparam int S    = 4;
    localparam int LAST = 1 + S + 3 * N;

    logic clk;
    logic rst;
    logic comp_out;
    logic comp1;
    logic cont;
    logic seq_init, seq_samp, seq_comp, seq_update;
    logic seq_init1, seq_samp1, seq_comp1, seq_update1;
    logic [2:0] state_dbg, state_dbg1;

    int n_chk = 0;
    int n_err = 0;

    logic [4:0] snap [0:63];

    adc_seqctrl_if #(.NBITS(N)) bus ();
    adc_seqctrl_if #(.NBITS(1)) bus1 ();

    adc_seqctrl #(.NBITS(N), .SAMP_CYCLES(S), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .seq_init(seq_init), .seq_samp(seq_samp), .seq_comp(seq_comp), .seq_update(seq_update),
        .comp_out(comp_out),
`ifdef ADC_SEQ_CONT_EN
        .cont(cont),
`endif
        .state_dbg(state_dbg)
    );

    adc_seqctrl #(.NBITS(1), .SAMP_CYCLES(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .seq_init(seq_init1), .seq_samp(seq_samp1), .seq_comp(seq_comp1), .seq_update(seq_update1),
        .comp_out(comp1),
`ifdef ADC_SEQ_CONT_EN
        .cont(1'b0),
`endif
        .state_dbg(state_dbg1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: a conversion is just a cycle offset d since the accepted start.
    logic        m_act;
    int          m_d;
    logic [15:0] m_word, m_res;
    logic        m_valid, m_ovr;

    function automatic logic [3:0] exp_strobes(input logic act, input int d);
        int o;
        if (!act) return 4'b0000;
        if (d == 1) return 4'b1000;
        if (d <= 1 + S) return 4'b0100;
        o = (d - 2 - S) % 3;
        if (o == 0) return 4'b0010;
        if (o == 1) return 4'b0000;
        return 4'b0001;
    endfunction

    initial begin
        logic done;
        logic [22:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_act = 0; m_d = 0; m_word = '0; m_res = '0; m_valid = 0; m_ovr = 0;
            end
            exp_v = {m_act, exp_strobes(m_act, m_d), m_valid, m_ovr, m_res};
            act_v = {bus.busy, seq_init, seq_samp, seq_comp, seq_update,
                     bus.result_valid, bus.overrun, bus.result};
            chk("cycle", 32'(act_v), 32'(exp_v));
            if (!rst) begin
                done = 1'b0;
                if (m_act) begin
                    if (m_d >= 2 + S && (m_d - 2 - S) % 3 == 1)
                        m_word[N - 1 - (m_d - 2 - S) / 3] = comp_out;
                    if (m_d == LAST) done = 1'b1;
                    else m_d++;
                end else if (bus.start) begin
                    m_act = 1; m_d = 1; m_word = '0;
                end
                if (done) begin
                    if (m_valid && !bus.result_ready) m_ovr = 1;
                    m_res = m_word;
                    m_valid = 1;
                    if (cont) m_d = 1;
                    else m_act = 0;
                end else if (m_valid && bus.result_ready) begin
                    m_valid = 0;
                end
            end
        end
    end

    // comp_out carries the wanted bit in the LATCH cycle and its inverse otherwise.
    function automatic logic cbit(input logic [15:0] pat, input int d);
        int o;
        o = d - 2 - S;
        if (o < 0) return 1'b0;
        if (o % 3 == 1) return pat[N - 1 - o / 3];
        return ~pat[N - 1 - o / 3];
    endfunction

    // Drives one conversion; returns in the cycle after completion (cycle 54).
    task automatic conv(input logic [15:0] pat, input bit hold, input bit rdy_last, input int abort_d);
        bus.start = 1'b1;
        tick();
        for (int d = 1; d <= LAST; d++) begin
            bus.start = hold;
            comp_out  = cbit(pat, d);
            if (rdy_last) bus.result_ready = (d == LAST);
            snap[d] = {seq_init, seq_samp, seq_comp, seq_update, bus.busy};
            if (d == abort_d) begin
                chk("pre_rst_comp", 32'(seq_comp), 32'd1);
                rst = 1'b1;
                #1;
                chk("rst_strobes", 32'({seq_init, seq_samp, seq_comp, seq_update}), 32'd0);
                chk("rst_busy", 32'(bus.busy), 32'd0);
                chk("rst_result", 32'(bus.result), 32'd0);
                chk("rst_flags", 32'({bus.result_valid, bus.overrun}), 32'd0);
                bus.start = 1'b0;
                tick();
                rst = 1'b0;
                return;
            end
            tick();
        end
        bus.start = 1'b0;
        comp_out  = 1'b0;
    endtask

    task automatic chk_timing(input string tag);
        chk({tag, "_c1"},  32'(snap[1]),  32'b10001);
        chk({tag, "_c2"},  32'(snap[2]),  32'b01001);
        chk({tag, "_c5"},  32'(snap[5]),  32'b01001);
        chk({tag, "_c6"},  32'(snap[6]),  32'b00101);
        chk({tag, "_c7"},  32'(snap[7]),  32'b00001);
        chk({tag, "_c8"},  32'(snap[8]),  32'b00011);
        chk({tag, "_c53"}, 32'(snap[53]), 32'b00011);
    endtask

    initial begin
        int n_comp, n_upd;
        logic [3:0] s1_c1, s1_c2;
        logic [15:0] pats [3];
        pats = '{16'h9D2E, 16'h0001, 16'hC35A};
        rst = 1'b1; cont = 1'b0; comp_out = 1'b0; comp1 = 1'b0;
        bus.start = 1'b0; bus.result_ready = 1'b0;
        bus1.start = 1'b0; bus1.result_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_result", 32'(bus.result), 32'd0);

        // Single conversion, consumer always ready
        bus.result_ready = 1'b1;
        conv(16'hA5C3, 1'b0, 1'b0, 0);
        chk("t1_result", 32'(bus.result), 32'h0000A5C3);
        chk("t1_valid", 32'(bus.result_valid), 32'd1);
        chk("t1_busy", 32'(bus.busy), 32'd0);
        chk_timing("t1");
        repeat (2) tick();

        // Completion and acceptance on the same edge
        bus.result_ready = 1'b0;
        conv(16'h0F0F, 1'b0, 1'b0, 0);
        conv(16'h3C3C, 1'b0, 1'b1, 0);
        chk("simul_result", 32'(bus.result), 32'h00003C3C);
        chk("simul_valid", 32'(bus.result_valid), 32'd1);
        chk("simul_ovr", 32'(bus.overrun), 32'd0);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;

        // Overrun
        conv(16'h1234, 1'b0, 1'b0, 0);
        conv(16'hFFFF, 1'b0, 1'b0, 0);
        chk("ovr_result", 32'(bus.result), 32'h0000FFFF);
        chk("ovr_valid", 32'(bus.result_valid), 32'd1);
        chk("ovr_flag", 32'(bus.overrun), 32'd1);
        bus.result_ready = 1'b1;
        tick();
        chk("ovr_drain_valid", 32'(bus.result_valid), 32'd0);
        chk("ovr_sticky", 32'(bus.overrun), 32'd1);

        // start held high throughout, then a start sampled in IDLE
        conv(16'h5A96, 1'b1, 1'b0, 0);
        chk("spam_busy", 32'(bus.busy), 32'd0);
        chk("spam_result", 32'(bus.result), 32'h00005A96);
        chk_timing("spam");
        conv(16'h6B2D, 1'b0, 1'b0, 0);
        chk("spam2_c1", 32'(snap[1]), 32'b10001);
        chk("spam2_result", 32'(bus.result), 32'h00006B2D);
        tick();

        // Reset in the COMP cycle of bit 7, then a fresh conversion
        conv(16'hC3A5, 1'b0, 1'b0, 2 + S + 3 * (N - 1 - 7));
        tick();
        conv(16'h8001, 1'b0, 1'b0, 0);
        chk("fresh_result", 32'(bus.result), 32'h00008001);
        chk("fresh_busy", 32'(bus.busy), 32'd0);
        chk_timing("fresh");
        tick();

        // NBITS=1, SAMP_CYCLES=1 instance
        bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        comp1 = 1'b1;
        n_comp = 0; n_upd = 0;
        s1_c1 = '0; s1_c2 = '0;
        for (int d = 1; d <= 5; d++) begin
            n_comp += int'(seq_comp1);
            n_upd  += int'(seq_update1);
            if (d == 1) s1_c1 = {seq_init1, seq_samp1, seq_comp1, seq_update1};
            if (d == 2) s1_c2 = {seq_init1, seq_samp1, seq_comp1, seq_update1};
            tick();
        end
        chk("n1_valid_c6", 32'(bus1.result_valid), 32'd1);
        chk("n1_result", 32'(bus1.result), 32'd1);
        chk("n1_comp_pulses", 32'(n_comp), 32'd1);
        chk("n1_update_pulses", 32'(n_upd), 32'd1);
        chk("n1_c1", 32'(s1_c1), 32'b1000);
        chk("n1_c2", 32'(s1_c2), 32'b0100);
        chk("n1_busy_c6", 32'(bus1.busy), 32'd0);
        comp1 = 1'b0;
        tick();

`ifdef ADC_SEQ_CONT_EN
        // Continuous mode: three conversions, cont dropped during the third
        bus.result_ready = 1'b1;
        cont = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            for (int d = 1; d <= LAST; d++) begin
                if (j == 2 && d == 20) cont = 1'b0;
                comp_out = cbit(pats[j], d);
                if (d == 1) chk("cont_init", 32'(seq_init), 32'd1);
                tick();
            end
            chk("cont_result", 32'(bus.result), 32'(pats[j]));
        end
        comp_out = 1'b0;
        chk("cont_end_busy", 32'(bus.busy), 32'd0);
        repeat (3) tick();
        chk("cont_idle", 32'(bus.busy), 32'd0);
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
